mc_controller_v2: RTL

// - Parametrised successor to the multicycle RV32I controller: FSM + ALU decode + imm decode for the shared-memory multicycle core.
// - Adds memory wait-state handshake with timeout, full branch set, jalr/lui/auipc, illegal-op trap, sticky error flags.
// - Sits between instruction register / ALU flags and the multicycle datapath; all datapath enables come from here.

---
 rtl/mc_controller_v2_if.sv | 17 +
 rtl/mc_controller_v2.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_v2_if.sv
`default_nettype none
// ============================================================================
//  Module     : mc_controller_v2_if
//  Description: Shared-memory bus handshake between the multicycle controller
//               (master) and the memory / datapath side (slave).
//  Revision   : 1.0 - initial release
// ============================================================================
interface mc_controller_v2_if;
  logic mem_ready;  // memory completes the current read/write this cycle
  logic memread;    // read request (fetch or load)
  logic memwrite;   // write request (store)
  logic adrsrc;     // address select: 0 = PC, 1 = ALUOut

  modport master (input mem_ready, output memread, memwrite, adrsrc);
  modport slave  (output mem_ready, input memread, memwrite, adrsrc);
endinterface
`default_nettype wire

// File: rtl/mc_controller_v2.sv
`default_nettype none
// ============================================================================
//  Module     : mc_controller_v2
//  Description: Multicycle RV32I controller - main FSM, ALU decode and
//               immediate decode, with memory wait-state timeout, illegal-op
//               trap and sticky error flags.
//  Config     : INSTRET_EN - when defined, builds the retired-instruction
//               counter; otherwise instret is tied to zero.
//  Revision   : 1.0 - initial release
// ============================================================================
module mc_controller_v2 #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  mc_controller_v2_if.master bus,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               lt,
  input  logic               ltu,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               regwrite,
  output logic [2:0]         immsrc,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         resultsrc,
  output logic [3:0]         alucontrol,
  output logic               illegal,
  output logic               bus_err,
  output logic               halted,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  // Wide enough to hold TIMEOUT-1, the last stalled count before a trap.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_EXECR  = 4'd6,  S_EXECI  = 4'd7,
    S_ALUWB   = 4'd8,  S_JAL     = 4'd9,  S_JALR   = 4'd10, S_JALRLNK = 4'd11,
    S_BRANCH  = 4'd12, S_LUI     = 4'd13, S_TRAP   = 4'd14
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_illegal;
  logic                r_bus_err;
  logic                w_illegal_op;
  logic                w_wait_state;
  logic                w_stall;
  logic                w_limit;
  logic                w_taken;

  // funct3/funct7b5 to ALU operation; sub only exists for R-type (op[5]).
  function automatic logic [3:0] alu_decode(input logic [6:0] o, input logic [2:0] f3,
                                            input logic f7);
    case (f3)
      3'b000:  alu_decode = (o[5] && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = 4'd7;
      3'b010:  alu_decode = 4'd5;
      3'b011:  alu_decode = 4'd6;
      3'b100:  alu_decode = 4'd4;
      3'b101:  alu_decode = f7 ? 4'd9 : 4'd8;
      3'b110:  alu_decode = 4'd3;
      default: alu_decode = 4'd2;
    endcase
  endfunction

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_stall      = w_wait_state && !bus.mem_ready;
  assign w_limit      = (TIMEOUT > 0) && (int'(r_wait) == TIMEOUT - 1);

  // Branch condition from ALU flags of rs1-rs2.
  always_comb begin
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = !zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = !lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = !ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state selection, including opcode dispatch and timeout trap.
  always_comb begin
    w_next       = r_state;
    w_illegal_op = 1'b0;
    case (r_state)
      S_FETCH:   if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_JAL:            w_next = S_JAL;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_ALUWB;
          OP_JALR: begin
            if (funct3 == 3'b000) w_next = S_JALR;
            else begin w_next = S_TRAP; w_illegal_op = 1'b1; end
          end
          OP_BRANCH: begin
            if (funct3[2:1] == 2'b01) begin w_next = S_TRAP; w_illegal_op = 1'b1; end
            else w_next = S_BRANCH;
          end
          default: begin w_next = S_TRAP; w_illegal_op = 1'b1; end
        endcase
      end
      S_MEMADR:  w_next = op[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (bus.mem_ready) w_next = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) w_next = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH: w_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALRLNK, S_LUI: w_next = S_ALUWB;
      S_JALR:    w_next = S_JALRLNK;
      default:   w_next = S_TRAP;
    endcase
    // A ready on the limit cycle has already taken the normal path above.
    if (w_stall && w_limit) w_next = S_TRAP;
  end

  // State, wait counter and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || !w_stall) r_wait <= '0;
      else                               r_wait <= r_wait + WAIT_W'(1);
      if (w_illegal_op)       r_illegal <= 1'b1;
      if (w_stall && w_limit) r_bus_err <= 1'b1;
    end
  end

  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign halted  = (r_state == S_TRAP);

  // Immediate format follows the opcode held in the instruction register.
  always_comb begin
    case (op)
      OP_STORE:         immsrc = 3'b001;
      OP_BRANCH:        immsrc = 3'b010;
      OP_JAL:           immsrc = 3'b011;
      OP_LUI, OP_AUIPC: immsrc = 3'b100;
      default:          immsrc = 3'b000;
    endcase
  end

  // Datapath controls: selects from state, enables gated by mem_ready/branch.
  always_comb begin
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.adrsrc   = 1'b0;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    resultsrc    = 2'b00;
    alucontrol   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        bus.memread = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        irwrite     = bus.mem_ready;
        pcwrite     = bus.mem_ready;
      end
      S_DECODE:  begin alusrca = 2'b01; alusrcb = 2'b01; end
      S_MEMADR:  begin alusrca = 2'b10; alusrcb = 2'b01; end
      S_MEMRD:   begin bus.memread = 1'b1; bus.adrsrc = 1'b1; end
      S_MEMWB:   begin regwrite = 1'b1; resultsrc = 2'b01; end
      S_MEMWR:   begin bus.memwrite = 1'b1; bus.adrsrc = 1'b1; end
      S_EXECR: begin
        alusrca    = 2'b10;
        alucontrol = alu_decode(op, funct3, funct7b5);
      end
      S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = alu_decode(op, funct3, funct7b5);
      end
      S_ALUWB:   regwrite = 1'b1;
      S_JAL:     begin alusrca = 2'b01; alusrcb = 2'b10; pcwrite = 1'b1; end
      S_JALR: begin
        alusrca   = 2'b10;
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      S_JALRLNK: begin alusrca = 2'b01; alusrcb = 2'b10; end
      S_BRANCH: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        pcwrite    = w_taken;
      end
      S_LUI:     begin alusrca = 2'b11; alusrcb = 2'b01; end
      default: ;
    endcase
  end

`ifdef INSTRET_EN
  logic [CNT_W-1:0] r_instret;

  // One retirement per return to FETCH from any other state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   r_instret <= '0;
    else if (r_state != S_FETCH && w_next == S_FETCH) r_instret <= r_instret + CNT_W'(1);
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

endmodule
`default_nettype wire
